// File: rtl/dp_pkg.sv
// dp_pkg: shared enumerations and status-bit positions for the datapath_seq slice.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // Bit positions inside the {N, V, Z} status word.
  localparam int ST_N = 2;
  localparam int ST_V = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: REG_N x DATA_W register file, one synchronous write port and one
// asynchronous read port. Indices at or beyond REG_N are write-ignored and read as 0.
// Contents are deliberately not reset.
module dp_regfile
  import dp_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int REG_N    = 8,
  localparam int REGSEL_W = (REG_N > 1) ? $clog2(REG_N) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [REGSEL_W-1:0] waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [REGSEL_W-1:0] raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [REG_N];

  // Write port: out-of-range targets are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < REG_N)) mem_q[waddr] <= wdata;
  end

  // Read port: combinational so a write on one edge is visible in the next cycle.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < REG_N) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle register-file datapath. One operation walks
// IDLE -> RDA -> RDB -> EXEC -> WB; external loads are taken only in IDLE.
// Optional build macro: DATAPATH_SEQ_OVF_EN builds the signed-overflow (V) flag;
// without it V is tied to 0.
module datapath_seq
  import dp_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int REG_N    = 8,
  localparam int REGSEL_W = (REG_N > 1) ? $clog2(REG_N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [REGSEL_W-1:0] load_num,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REGSEL_W-1:0] op_rn,
  input  logic [REGSEL_W-1:0] op_rm,
  input  logic [REGSEL_W-1:0] op_rd,
  input  logic [1:0]          op_shift,
  input  logic [1:0]          op_aluop,
  input  logic                op_asel,
  input  logic                op_bsel,
  input  logic [DATA_W-1:0]   op_imm,
  input  logic                op_loads,
  output logic                done,
  output logic [DATA_W-1:0]   datapath_out,
  output logic [2:0]          status
);

  // B-operand shifter.
  function automatic logic signed [DATA_W-1:0] shift_b(input logic [1:0] sh,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    case (sh)
      SH_LSL1: r = b <<< 1;
      SH_LSR1: r = $signed($unsigned(b) >> 1);
      SH_ASR1: r = b >>> 1;
      default: r = b;
    endcase
    return r;
  endfunction

  // ALU, result wraps modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] alu(input logic [1:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      default: r = ~b;
    endcase
    return r;
  endfunction

`ifdef DATAPATH_SEQ_OVF_EN
  // Two's-complement overflow of add/subtract from operand and result sign bits.
  function automatic logic ovf(input logic [1:0] op,
                               input logic signed [DATA_W-1:0] a,
                               input logic signed [DATA_W-1:0] b,
                               input logic signed [DATA_W-1:0] r);
    logic v;
    case (op)
      ALU_ADD: v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      default: v = 1'b0;
    endcase
    return v;
  endfunction
`endif

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]               status_q, status_d;

  logic [REGSEL_W-1:0]      rn_q, rm_q, rd_q;
  logic [1:0]               shift_q, aluop_q;
  logic                     asel_q, bsel_q, loads_q;
  logic signed [DATA_W-1:0] imm_q;

  logic                     req_fire, load_fire;
  logic                     rf_we;
  logic [REGSEL_W-1:0]      rf_waddr, rf_raddr;
  logic [DATA_W-1:0]        rf_wdata, rf_rdata;
  logic signed [DATA_W-1:0] ain, bin, alu_res;
  logic                     v_flag;

  assign req_ready    = (state_q == S_IDLE);
  assign load_ready   = (state_q == S_IDLE);
  assign req_fire     = req_valid && req_ready;
  assign load_fire    = load_valid && load_ready && !reset;
  assign done         = (state_q == S_WB);
  assign datapath_out = c_q;
  assign status       = status_q;

  // Single write port shared by writeback and external loads (never both: loads only in IDLE).
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = load_num;
    rf_wdata = load_data;
    if (state_q == S_WB) begin
      rf_we    = !reset;
      rf_waddr = rd_q;
      rf_wdata = c_q;
    end else if (load_fire) begin
      rf_we = 1'b1;
    end
  end

  assign rf_raddr = (state_q == S_RDA) ? rn_q : rm_q;

  dp_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // Operand selection, shifter and ALU on the latched operands.
  always_comb begin
    ain     = asel_q ? '0 : a_q;
    bin     = bsel_q ? imm_q : shift_b(shift_q, b_q);
    alu_res = alu(aluop_q, ain, bin);
`ifdef DATAPATH_SEQ_OVF_EN
    v_flag  = ovf(aluop_q, ain, bin, alu_res);
`else
    v_flag  = 1'b0;
`endif
  end

  // Next state and next operand/result/status values.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: if (req_fire) state_d = S_RDA;
      S_RDA: begin
        a_d     = $signed(rf_rdata);
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d     = $signed(rf_rdata);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (loads_q) begin
          status_d[ST_N] = alu_res[DATA_W-1];
          status_d[ST_V] = v_flag;
          status_d[ST_Z] = (alu_res == '0);
        end
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand, result and status registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  // Request fields are captured on acceptance only.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      rn_q    <= op_rn;
      rm_q    <= op_rm;
      rd_q    <= op_rd;
      shift_q <= op_shift;
      aluop_q <= op_aluop;
      asel_q  <= op_asel;
      bsel_q  <= op_bsel;
      imm_q   <= $signed(op_imm);
      loads_q <= op_loads;
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: scoreboard bench for datapath_seq (default parameters).
module tb_datapath_seq;

  localparam int  W = 16;
  localparam longint M = 64'd65536;
  localparam longint H = 64'd32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_ready;
  logic [2:0]  load_num;
  logic [15:0] load_data;
  logic        req_valid, req_ready;
  logic [2:0]  op_rn, op_rm, op_rd;
  logic [1:0]  op_shift, op_aluop;
  logic        op_asel, op_bsel, op_loads;
  logic [15:0] op_imm;
  logic        done;
  logic [15:0] datapath_out;
  logic [2:0]  status;

  datapath_seq #(.DATA_W(16), .REG_N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_num     (load_num),
    .load_data    (load_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op_rn        (op_rn),
    .op_rm        (op_rm),
    .op_rd        (op_rd),
    .op_shift     (op_shift),
    .op_aluop     (op_aluop),
    .op_asel      (op_asel),
    .op_bsel      (op_bsel),
    .op_imm       (op_imm),
    .op_loads     (op_loads),
    .done         (done),
    .datapath_out (datapath_out),
    .status       (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  st;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mR[8];
  logic [2:0]  mStat;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: evaluates one operation from the register-level rules with integer arithmetic.
  function automatic void model_exec(input int rn, input int rm, input int rd, input int sh,
                                     input int aop, input bit asel, input bit bsel,
                                     input logic [15:0] imm, input bit loads,
                                     output logic [15:0] res, output logic [2:0] st);
    longint a, b, bs, r, sa, sb, t;
    bit v;
    a = asel ? 0 : longint'(mR[rn]);
    b = longint'(mR[rm]);
    case (sh)
      1:       bs = (b * 2) % M;
      2:       bs = b / 2;
      3:       bs = b / 2 + ((b >= H) ? H : 0);
      default: bs = b;
    endcase
    if (bsel) bs = longint'(imm);
    sa = (a >= H) ? a - M : a;
    sb = (bs >= H) ? bs - M : bs;
    v = 1'b0;
    case (aop)
      0: begin r = (a + bs) % M;     t = sa + sb; v = (t > H - 1) || (t < -H); end
      1: begin r = (a - bs + M) % M; t = sa - sb; v = (t > H - 1) || (t < -H); end
      2: r = a & bs;
      default: r = M - 1 - bs;
    endcase
`ifndef DATAPATH_SEQ_OVF_EN
    v = 1'b0;
`endif
    mR[rd] = r[15:0];
    if (loads) mStat = {(r >= H), v, (r == 0)};
    res = r[15:0];
    st  = mStat;
  endfunction

  task automatic do_load(input int num, input logic [15:0] d);
    int g = 0;
    @(negedge clk);
    while (!load_ready && g < 40) begin @(negedge clk); g++; end
    if (!load_ready) begin
      n_tests++; n_fail++;
      $display("FAIL load_wait: load_ready got 0, expected 1");
      return;
    end
    load_valid = 1'b1; load_num = 3'(num); load_data = d; mR[num] = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic issue(input int rn, input int rm, input int rd, input int sh, input int aop,
                       input bit asel, input bit bsel, input logic [15:0] imm, input bit loads,
                       input bit wl, input int lnum, input logic [15:0] ldata, input bit exp_done);
    int g = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && g < 40) begin @(negedge clk); g++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_wait: req_ready got 0, expected 1");
      return;
    end
    op_rn = 3'(rn); op_rm = 3'(rm); op_rd = 3'(rd); op_shift = 2'(sh); op_aluop = 2'(aop);
    op_asel = asel; op_bsel = bsel; op_imm = imm; op_loads = loads;
    req_valid = 1'b1;
    if (wl) begin
      load_valid = 1'b1; load_num = 3'(lnum); load_data = ldata; mR[lnum] = ldata;
    end
    if (exp_done) begin
      model_exec(rn, rm, rd, sh, aop, asel, bsel, imm, loads, e.res, e.st);
      e.acc = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0; load_valid = 1'b0;
    op_rn = '0; op_imm = $urandom_range(0, 65535);
  endtask

  // Reads register r back by running R[r] + imm(0) into R[r].
  task automatic readback(input int r);
    issue(r, 0, r, 0, 0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 16'h0, 1'b1);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        e = sb_q.pop_front();
        check("result", longint'(datapath_out), longint'(e.res));
        check("status", longint'(status), longint'(e.st));
        check("latency", longint'(cyc - e.acc), 4);
      end
    end
  end

  initial begin
    int g;
    reset = 1'b1; load_valid = 1'b0; req_valid = 1'b0;
    load_num = '0; load_data = '0; op_rn = '0; op_rm = '0; op_rd = '0;
    op_shift = '0; op_aluop = '0; op_asel = 1'b0; op_bsel = 1'b0; op_imm = '0; op_loads = 1'b0;
    mStat = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_load_ready", load_ready, 1);
    check("rst_done", done, 0);
    check("rst_out", datapath_out, 0);
    check("rst_status", status, 0);

    for (int i = 0; i < 8; i++) do_load(i, 16'($urandom_range(0, 65535)));

    // Shifted add: 3 + (4 << 1) = 11 into R2, then read R2 back.
    do_load(0, 16'd3);
    do_load(1, 16'd4);
    issue(0, 1, 2, 1, 0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b1);
    readback(2);

    // Subtract to zero loads Z; a following op without loads keeps status.
    do_load(3, 16'd4);
    do_load(4, 16'd4);
    issue(3, 4, 5, 0, 1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b1);
    issue(0, 1, 7, 0, 0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b1);

    // 0x7FFF + 1: N set, V set only when the overflow flag is built.
    do_load(6, 16'h7FFF);
    issue(6, 0, 7, 0, 0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 0, 16'h0, 1'b1);

    // Reset while the op sits in EXEC: no writeback, no done, status cleared.
    issue(0, 1, 5, 0, 0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstx_req_ready", req_ready, 1);
    check("rstx_status", status, 0);
    check("rstx_out", datapath_out, 0);
    check("rstx_done", done, 0);
    reset = 1'b0;
    mStat = 3'b000;
    readback(5);

    // Load held during RDB must wait for IDLE; it lands after the writeback to the same register.
    issue(0, 1, 4, 0, 0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b1);
    @(negedge clk);
    load_valid = 1'b1; load_num = 3'd4; load_data = 16'h1234;
    check("busy_load_ready", load_ready, 0);
    g = 0;
    while (!load_ready && g < 20) begin @(negedge clk); g++; end
    check("idle_load_ready", load_ready, 1);
    mR[4] = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    readback(4);

    // Load and request accepted together: RDA sees the freshly written value.
    issue(5, 0, 6, 0, 0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b1, 5, 16'h00F0, 1'b1);
    readback(6);

    // Randomized mix of operations and loads.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 7), 16'($urandom_range(0, 65535)));
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            16'($urandom_range(0, 65535)), 1'b1);
    end
    for (int i = 0; i < 8; i++) readback(i);

    g = 0;
    while (sb_q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    check("drain", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
